// File: rtl/ram16_arbiter.sv
// ram16_arbiter: shares one single-port 1-cycle-latency RAM between ports A and B,
// one access per clock, round-robin or A-priority on conflict.
module ram16_arbiter #(
  parameter int ADDR_WIDTH  = 4,
  parameter int DATA_WIDTH  = 16,
  parameter int ROUND_ROBIN = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  a_req,
  input  logic                  a_we,
  input  logic [ADDR_WIDTH-1:0] a_addr,
  input  logic [DATA_WIDTH-1:0] a_wdata,
  output logic                  a_gnt,
  output logic                  a_rvalid,
  output logic [DATA_WIDTH-1:0] a_rdata,
  input  logic                  b_req,
  input  logic                  b_we,
  input  logic [ADDR_WIDTH-1:0] b_addr,
  input  logic [DATA_WIDTH-1:0] b_wdata,
  output logic                  b_gnt,
  output logic                  b_rvalid,
  output logic [DATA_WIDTH-1:0] b_rdata,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic [DATA_WIDTH-1:0] mem_in,
  output logic                  mem_load,
  input  logic [DATA_WIDTH-1:0] mem_out
);
  logic last_b_q, last_b_d;
  logic a_own_q, b_own_q;
  always_comb begin
    a_gnt       = !reset && a_req && (!b_req || ROUND_ROBIN == 0 || last_b_q);
    b_gnt       = !reset && b_req && !a_gnt;
    last_b_d    = a_gnt ? 1'b0 : (b_gnt ? 1'b1 : last_b_q);
    mem_address = b_gnt ? b_addr : a_addr;
    mem_in      = b_gnt ? b_wdata : a_wdata;
    mem_load    = a_gnt ? a_we : (b_gnt && b_we);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      last_b_q <= 1'b1;
      a_own_q  <= 1'b0;
      b_own_q  <= 1'b0;
    end else begin
      last_b_q <= last_b_d;
      a_own_q  <= a_gnt;
      b_own_q  <= b_gnt;
    end
  end
  // A response owed from the edge before reset is suppressed while reset is high.
  assign a_rvalid = a_own_q && !reset;
  assign b_rvalid = b_own_q && !reset;
  assign a_rdata  = mem_out;
  assign b_rdata  = mem_out;
endmodule

// File: doc/ram16_arbiter.md
Name: ram16_arbiter

Overview:
- Two-requester arbiter that shares one single-port, 16-word synchronous RAM between port A (CPU data side) and port B (loader/debug side).
- Grants at most one access per clock. Round-robin or fixed priority on conflict.
- Drives the RAM address/data/load lines and steers the 1-cycle-latency read data back to the granted requester with a valid strobe.
- Sits between the CPU/loader and the ram16 memory instance.

Parameters:
- ADDR_WIDTH, 4, RAM address width (16 words).
- DATA_WIDTH, 16, data word width.
- ROUND_ROBIN, 1. 1 = alternate on conflict. 0 = port A always wins.

Ports:
- clk  input  1  system clock; all state on rising edge
- reset  input  1  synchronous, active-high reset
- a_req  input  1  port A access request
- a_we  input  1  port A write enable (1 = write, 0 = read)
- a_addr  input  ADDR_WIDTH  port A word address
- a_wdata  input  DATA_WIDTH  port A write data
- a_gnt  output  1  port A request accepted this cycle (combinational)
- a_rvalid  output  1  port A response valid
- a_rdata  output  DATA_WIDTH  port A response data
- b_req, b_we, b_addr, b_wdata, b_gnt, b_rvalid, b_rdata  same as port A, for port B
- mem_address  output  ADDR_WIDTH  to RAM address
- mem_in  output  DATA_WIDTH  to RAM write data
- mem_load  output  1  to RAM load
- mem_out  input  DATA_WIDTH  from RAM out (registered in RAM, 1-cycle latency)

Behaviour:
- Clock and reset: clock is clk; reset is synchronous, active-high.
- Reset values: a_rvalid=0, b_rvalid=0, last_grant=B (so A wins the first conflict), resp_owner=none.
  - While reset=1: a_gnt=b_gnt=0 and mem_load=0.
- Grant logic (combinational, same cycle as req):
  - Only A requests -> A granted.
  - Only B requests -> B granted.
  - Both request, ROUND_ROBIN=1 -> grant the port that is not last_grant.
  - Both request, ROUND_ROBIN=0 -> grant A.
  - Neither requests -> no grant.
- last_grant updates at the clock edge to whichever port was granted. It holds when there is no grant.
- Requester rules:
  - Req, we, addr and wdata must be held stable until the cycle in which gnt=1.
  - The transaction is accepted at the clock edge ending that cycle.
  - Req may drop or change to a new request in the following cycle (back-to-back allowed).
- RAM drive:
  - mem_address, mem_in and mem_load = {granted addr, granted wdata, granted we}.
  - With no grant: mem_address = a_addr, mem_in = a_wdata, mem_load=0.
- Response:
  - resp_owner is registered at the grant edge.
  - In the following cycle, rvalid=1 for that owner only, and rdata = mem_out.
  - For a read, rdata is memory[addr].
  - For a write, rdata echoes the written data (write acknowledge).
  - The non-owner's rvalid is 0. Its rdata is don't-care; the implementation drives mem_out to both ports.
- Latency and throughput:
  - Grant-to-rvalid latency is exactly 1 cycle.
  - Sustained throughput is 1 access per cycle in total.
  - Under continuous dual requests with ROUND_ROBIN=1, grants strictly alternate, so a port waits at most 1 cycle.
- Read after write to the same address on consecutive grants (either port): the read returns the new data.
- Reset mid-operation: a response due in the cycle after reset is dropped (rvalid stays 0). The RAM contents are not cleared.
- ROUND_ROBIN=0: B can starve under continuous A requests. This is permitted and documented.

Test Plan:
- Reset, then A writes addr 3 = 0x1234 (one cycle). Then A reads addr 3 -> a_gnt=1 in each request cycle; a_rvalid=1 one cycle after each grant with a_rdata=0x1234 both times; b_rvalid=0 throughout.
- Both ports read every cycle for 6 cycles (A addr 1, B addr 2, preloaded 0x00A1 / 0x00B2) with ROUND_ROBIN=1 -> grants A,B,A,B,A,B. The rvalids alternate one cycle later with the matching data.
- Same stimulus with ROUND_ROBIN=0 -> a_gnt=1 in all 6 cycles; b_gnt=0 throughout; b_rvalid never asserted.
- B writes addr 15 = 0xFFFF while A reads addr 15 in the next cycle -> A's a_rdata=0xFFFF. A write to addr 0 does not disturb addr 15.
- A is granted a read in cycle N; reset is asserted in cycle N+1 -> a_rvalid=0 in N+1. After reset, the first conflict is granted to A.
- Requests held without a grant: B holds b_req with addr 7 while losing to A for 1 cycle -> b_gnt is asserted in the next cycle. b_rdata is the addr 7 contents, one cycle after the grant.
